// File: rtl/xls_fifo_push_arbiter_if.sv
// Producer/consumer bundle for xls_fifo_push_arbiter: NumInputs ready/valid producers
// merged onto one tagged consumer channel.
interface xls_fifo_push_arbiter_if #(
  parameter int Width     = 32,
  parameter int NumInputs = 4
);
  localparam int IdxWidth = $clog2(NumInputs);

  logic [NumInputs*Width-1:0] in_data;
  logic [NumInputs-1:0]       in_valid;
  logic [NumInputs-1:0]       in_last;
  logic [NumInputs-1:0]       in_ready;
  logic [Width-1:0]           out_data;
  logic [IdxWidth-1:0]        out_idx;
  logic                       out_last;
  logic                       out_valid;
  logic                       out_ready;

  // Environment side: drives producers and the consumer's ready.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid
  );

  // Arbiter side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/xls_fifo_push_arbiter.sv
// Round-robin arbiter feeding a single-entry output slot tagged with the producer index.
// Optional burst lock (hold grant until in_last) enabled by XLS_FIFO_ARB_BURST_LOCK_EN.
module xls_fifo_push_arbiter #(
  parameter int Width     = 32,
  parameter int NumInputs = 4
) (
  input logic                   clk,
  input logic                   rst,
  xls_fifo_push_arbiter_if.slave bus
);
  localparam int IdxWidth = $clog2(NumInputs);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumInputs - 1);

  logic                 full;
  logic [Width-1:0]     data_q;
  logic [IdxWidth-1:0]  idx_q;
  logic                 last_q;
  logic [IdxWidth-1:0]  last_grant;

  logic                 accept;
  logic                 grant_any;
  logic                 transfer;
  logic [IdxWidth-1:0]  grant_idx;
  logic [IdxWidth-1:0]  cand_idx;
  logic [NumInputs-1:0] eligible;
  logic [NumInputs-1:0] grant;
  logic [NumInputs-1:0] ready;
  int                   cand;

`ifdef XLS_FIFO_ARB_BURST_LOCK_EN
  logic                lock;
  logic [IdxWidth-1:0] lock_idx;

  // While a burst is open only its owner may compete, even if it is idle.
  always_comb begin
    eligible = bus.in_valid;
    if (lock) begin
      eligible = bus.in_valid & (NumInputs'(1) << lock_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (transfer) begin
      lock     <= !bus.in_last[grant_idx];
      lock_idx <= grant_idx;
    end
  end
`else
  always_comb begin
    eligible = bus.in_valid;
  end
`endif

  // Search starts one past the previous winner and wraps at NumInputs, not at 2**IdxWidth.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NumInputs; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NumInputs) begin
        cand = cand - NumInputs;
      end
      cand_idx = IdxWidth'(cand);
      if (!grant_any && eligible[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign accept   = !full || bus.out_ready;
  assign grant    = grant_any ? (NumInputs'(1) << grant_idx) : '0;
  assign ready    = (!rst && accept) ? grant : '0;
  assign transfer = |ready;

  // A pop and a refill in the same cycle keep full set: zero-bubble handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      last_grant <= LastIdx;
    end else if (transfer) begin
      full       <= 1'b1;
      data_q     <= bus.in_data[grant_idx*Width +: Width];
      idx_q      <= grant_idx;
      last_q     <= bus.in_last[grant_idx];
      last_grant <= grant_idx;
    end else if (full && bus.out_ready) begin
      full <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = full;
endmodule

// File: tb/tb_xls_fifo_push_arbiter.sv
// Self-checking bench for xls_fifo_push_arbiter: a 4-input and a 3-input instance
// against a behavioural model, directed scenarios then randomized traffic.
module tb_xls_fifo_push_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xls_fifo_push_arbiter_if #(.Width(W), .NumInputs(4)) bus4 ();
  xls_fifo_push_arbiter_if #(.Width(W), .NumInputs(3)) bus3 ();

  xls_fifo_push_arbiter #(.Width(W), .NumInputs(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  xls_fifo_push_arbiter #(.Width(W), .NumInputs(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int tests = 0;
  int fails = 0;

  // Model state per instance: 0 = four inputs, 1 = three inputs.
  int         n_of [2] = '{4, 3};
  bit         m_full [2];
  logic [W-1:0] m_data [2];
  int         m_idx [2];
  bit         m_last [2];
  int         m_lg [2];
  bit         m_lock [2];
  int         m_lki [2];
  int         exp_g [2];
  logic [3:0] exp_ready [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] vld(input int k);
    if (k == 0) return bus4.in_valid;
    return {1'b0, bus3.in_valid};
  endfunction

  function automatic logic [3:0] lst(input int k);
    if (k == 0) return bus4.in_last;
    return {1'b0, bus3.in_last};
  endfunction

  function automatic logic [W-1:0] dat(input int k, input int i);
    if (k == 0) return bus4.in_data[i*W +: W];
    return bus3.in_data[i*W +: W];
  endfunction

  function automatic bit ordy(input int k);
    if (k == 0) return bus4.out_ready;
    return bus3.out_ready;
  endfunction

  // Winner = valid index at the smallest circular distance after the previous winner.
  function automatic int pick(input int n, input logic [3:0] v, input int lg, input bit lk, input int lki);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = n;
    if (lk) return v[lki] ? lki : -1;
    for (int i = 0; i < n; i++) begin
      if (v[i]) begin
        d = (((i - lg - 1) % n) + n) % n;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic modelPredict();
    bit acc;
    int g;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        exp_g[k]     = -1;
        exp_ready[k] = 4'b0;
      end else begin
        acc = !m_full[k] || ordy(k);
        g   = pick(n_of[k], vld(k), m_lg[k], m_lock[k], m_lki[k]);
        exp_g[k]     = acc ? g : -1;
        exp_ready[k] = (exp_g[k] >= 0) ? 4'(1 << exp_g[k]) : 4'b0;
      end
    end
  endtask

  task automatic modelUpdate();
    logic [3:0] l;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_full[k] = 1'b0;
        m_data[k] = '0;
        m_idx[k]  = 0;
        m_last[k] = 1'b0;
        m_lg[k]   = n_of[k] - 1;
        m_lock[k] = 1'b0;
        m_lki[k]  = 0;
      end else if (exp_g[k] >= 0) begin
        l = lst(k);
        m_full[k] = 1'b1;
        m_data[k] = dat(k, exp_g[k]);
        m_idx[k]  = exp_g[k];
        m_last[k] = l[exp_g[k]];
        m_lg[k]   = exp_g[k];
`ifdef XLS_FIFO_ARB_BURST_LOCK_EN
        m_lock[k] = !m_last[k];
        m_lki[k]  = exp_g[k];
`endif
      end else if (m_full[k] && ordy(k)) begin
        m_full[k] = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    check("ready4", 32'(bus4.in_ready), 32'(exp_ready[0]));
    check("valid4", 32'(bus4.out_valid), 32'(m_full[0]));
    check("data4", bus4.out_data, m_data[0]);
    check("idx4", 32'(bus4.out_idx), 32'(m_idx[0]));
    check("last4", 32'(bus4.out_last), 32'(m_last[0]));
    check("ready3", 32'(bus3.in_ready), 32'(exp_ready[1][2:0]));
    check("valid3", 32'(bus3.out_valid), 32'(m_full[1]));
    check("data3", bus3.out_data, m_data[1]);
    check("idx3", 32'(bus3.out_idx), 32'(m_idx[1]));
    check("last3", 32'(bus3.out_last), 32'(m_last[1]));
  endtask

  // One clock: inputs were set at the falling edge; returns at the next falling edge.
  task automatic applyStimulus();
    #1;
    modelPredict();
    checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    bus4.in_valid  = '0;
    bus4.in_last   = '0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b0;
    bus3.in_valid  = '0;
    bus3.in_last   = '0;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    idleInputs();
    applyStimulus();
    rst = 1'b0;
  endtask

  logic [2:0] t4_valid [4] = '{3'b100, 3'b110, 3'b101, 3'b011};
  logic [2:0] t4_ready [4] = '{3'b100, 3'b010, 3'b100, 3'b001};
`ifdef XLS_FIFO_ARB_BURST_LOCK_EN
  int burst_order [4] = '{0, 0, 0, 1};
`else
  int burst_order [4] = '{0, 1, 0, 1};
`endif

  initial begin
    int cnt0;
    rst = 1'b1;
    idleInputs();
    bus4.in_valid = 4'hF;
    bus3.in_valid = 3'h7;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    applyStimulus();
    check("rst_ready_zero", 32'(bus4.in_ready), 32'h0);

    // Idle, then a single producer on lane 2.
    rst = 1'b0;
    idleInputs();
    #1;
    check("idle_ready", 32'(bus4.in_ready), 32'h0);
    check("idle_valid", 32'(bus4.out_valid), 32'h0);
    applyStimulus();
    bus4.in_valid = 4'b0100;
    bus4.in_data[2*W +: W] = 32'hA5;
    #1;
    check("t1_ready", 32'(bus4.in_ready), 32'h4);
    applyStimulus();
    check("t1_data", bus4.out_data, 32'hA5);
    check("t1_idx", 32'(bus4.out_idx), 32'd2);

    // All valid: strict rotation, one word per cycle.
    pulseReset();
    bus4.in_valid  = 4'hF;
    bus4.in_last   = 4'hF;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus4.in_data[i*W +: W] = 32'hD0 + 32'(i);
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rot_ready", 32'(bus4.in_ready), 32'(1 << (c % 4)));
      applyStimulus();
      check("rot_idx", 32'(bus4.out_idx), 32'(c % 4));
      check("rot_valid", 32'(bus4.out_valid), 32'h1);
    end

    // Backpressure holds the slot, then pop and refill together.
    bus4.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 32'(bus4.in_ready), 32'h0);
      applyStimulus();
      check("bp_data", bus4.out_data, 32'hD3);
    end
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 4'b0010;
    #1;
    check("refill_ready", 32'(bus4.in_ready), 32'h2);
    applyStimulus();
    check("refill_valid", 32'(bus4.out_valid), 32'h1);
    check("refill_data", bus4.out_data, 32'hD1);

    // Three-input wrap: index 2 wraps to 0, never to 3.
    pulseReset();
    bus3.out_ready = 1'b1;
    bus3.in_last   = 3'h7;
    for (int i = 0; i < 3; i++) bus3.in_data[i*W +: W] = 32'h30 + 32'(i);
    for (int c = 0; c < 4; c++) begin
      bus3.in_valid = t4_valid[c];
      #1;
      check("wrap3_ready", 32'(bus3.in_ready), 32'(t4_ready[c]));
      applyStimulus();
    end

    // Reset while holding a word drops it and restores producer 0 priority.
    pulseReset();
    bus4.in_valid = 4'b0100;
    bus4.in_data[2*W +: W] = 32'h1234;
    applyStimulus();
    check("midrst_data_pre", bus4.out_data, 32'h1234);
    rst = 1'b1;
    applyStimulus();
    check("midrst_valid", 32'(bus4.out_valid), 32'h0);
    check("midrst_data", bus4.out_data, 32'h0);
    rst = 1'b0;
    bus4.in_valid = 4'hF;
    bus4.in_last  = 4'hF;
    #1;
    check("midrst_ptr", 32'(bus4.in_ready), 32'h1);
    applyStimulus();

    // Burst of three from producer 0 while producer 1 waits.
    pulseReset();
    bus4.out_ready = 1'b1;
    bus4.in_data[0 +: W] = 32'hB0;
    bus4.in_data[W +: W] = 32'hB1;
    cnt0 = 0;
    for (int c = 0; c < 4; c++) begin
      bus4.in_valid = {2'b00, 1'b1, cnt0 < 3};
      bus4.in_last  = {2'b00, 1'b1, cnt0 == 2};
      #1;
      check("burst_ready", 32'(bus4.in_ready), 32'(1 << burst_order[c]));
      if (burst_order[c] == 0) cnt0++;
      applyStimulus();
    end

    // Randomized traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus4.in_valid  = 4'($urandom);
      bus4.in_last   = 4'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) bus4.in_data[i*W +: W] = $urandom;
      bus3.in_valid  = 3'($urandom);
      bus3.in_last   = 3'($urandom);
      bus3.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) bus3.in_data[i*W +: W] = $urandom;
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xls_fifo_push_arbiter.md
# xls_fifo_push_arbiter

Round-robin arbiter that shares one single-entry output stage between `NumInputs` ready/valid producers. It merges producer streams onto one consumer channel and tags each word with the index of the producer that sent it. It sits in front of a shared depth-1 FIFO or decoder stage in the zstd datapath, where several procs compete for one downstream channel. An optional burst lock keeps a grant until a producer marks its last word.

## Interface
- `Width`, 32, data width of each channel.
- `NumInputs`, 4, number of producers; legal range 2..16.
- `IdxWidth`, `$clog2(NumInputs)` (localparam), width of `out_idx`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  `NumInputs*Width`  producer data; producer i occupies bits `[i*Width +: Width]`.
- `in_valid`  in  `NumInputs`  producer i has a word.
- `in_last`  in  `NumInputs`  word from producer i ends a burst.
- `in_ready`  out  `NumInputs`  word from producer i is accepted this cycle; at most one bit is set (one-hot or zero).
- `out_data`  out  `Width`  registered data of the output slot.
- `out_idx`  out  `IdxWidth`  producer index of the word in `out_data`.
- `out_last`  out  1  registered `in_last` of that word.
- `out_valid`  out  1  output slot full.
- `out_ready`  in  1  consumer accepts the slot contents.

## Operation
- Output slot: a register set (`out_data`, `out_idx`, `out_last`) plus a `full` flag. `out_valid = full`.
- Accept condition: `accept = !full || out_ready`. The slot is refilled in the same cycle it is popped.
- Round-robin pointer `last_grant` (`IdxWidth` bits).
  - Search order starts at `last_grant+1` and wraps modulo `NumInputs`. This includes non-power-of-two `NumInputs`: index `NumInputs-1` wraps to 0.
  - The first index with `in_valid` set wins.
- `in_ready[i] = accept && grant[i]`. `in_ready` depends combinationally on `in_valid` and `out_ready`, and this is permitted.
  - A producer must not make `in_valid` depend on `in_ready`.
- Transfer on input i (`in_valid[i] && in_ready[i]`):
  - load `out_data <= in_data[i]`, `out_idx <= i`, `out_last <= in_last[i]`;
  - set `full <= 1`;
  - set `last_grant <= i`.
- Pop without a new transfer (`full && out_ready` and no grant): `full <= 0`. The data registers hold their values.
- No valid input and no pop: all state holds.
- Simultaneous pop and transfer: `full` stays 1 and the new word replaces the old one. This is a zero-bubble handoff.
- Reset values:
  - `full=0` and `out_valid=0`;
  - `out_data=0`, `out_idx=0`, `out_last=0`;
  - `last_grant=NumInputs-1`, so producer 0 has first priority;
  - lock cleared.
  - `in_ready` is 0 during reset.
- Reset mid-operation drops any word held in the slot. No partial transfer survives.
- Fairness: with all inputs continuously valid and `out_ready=1`, grants rotate 0,1,…,N-1,0. The worst-case wait is N-1 transfers.

## Timing
- Latency: a word accepted in cycle t appears on `out_valid`/`out_data` in cycle t+1.
- Throughput: 1 word/cycle sustained when `out_ready=1`.
- Backpressure: when `full && !out_ready`, all `in_ready` bits are 0. The slot and pointer hold.
- `out_*` are register outputs with no combinational input-to-output path. `in_ready` is combinational from `in_valid`, `out_ready`, `full` and the lock state.

## Configuration
- `XLS_FIFO_ARB_BURST_LOCK_EN` defined: burst lock is enabled.
  - A transfer from producer i with `in_last[i]=0` sets `lock=1` and `lock_idx=i`.
  - While locked, only producer i can be granted. Other valid inputs wait, even if producer i is idle.
  - A transfer from producer i with `in_last[i]=1` clears the lock.
  - The pointer updates normally, so rotation continues after the burst ends.
- Macro undefined: there is no lock state. Every transfer is arbitrated independently, and `in_last` is only forwarded to `out_last`.

## Test plan
- Reset, then drive `in_valid=4'b0000` → `out_valid=0`, `in_ready=0`. After `in_valid[2]=1` with `data=0xA5`: `in_ready=4'b0100`, and next cycle `out_data=0xA5`, `out_idx=2`.
- All four inputs valid, `out_ready=1`, 8 cycles → grant sequence 0,1,2,3,0,1,2,3 and one word per cycle with no bubbles.
- Slot full with `out_ready=0` for 5 cycles → `in_ready=0`, `out_data` stable. Raising `out_ready` with input 1 valid pops and refills in the same cycle, so `out_valid` stays 1.
- `NumInputs=3`, inputs 1 and 2 valid after a grant to 2 → next grant goes to 1 (order 0 → 1, input 0 idle). The pointer wraps correctly with no grant to index 3.
- Assert `rst` while `out_valid=1` with `out_data=0x1234` → next cycle `out_valid=0`, `out_data=0`, `last_grant=NumInputs-1`.
- With `XLS_FIFO_ARB_BURST_LOCK_EN`: input 0 sends 3 words with `last` pattern 0,0,1 while input 1 stays valid → input 1 is not granted until input 0's third word transfers. Without the macro, the grants interleave as 0,1,0,1.
